if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; producer side of the IF/ID interface.

---
 rtl/if_stage_pkg.sv | 38 +++
 rtl/if_stage_ins_classify.sv | 24 ++
 rtl/if_stage.sv | 185 ++++++++++++++++++
 tb/tb_if_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: MIPS opcodes, IF_ins_type
// class codes, fetch FSM state encodings and the PC increment helper.
package if_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] TYPE_NOP    = 4'd0;
  localparam logic [3:0] TYPE_RTYPE  = 4'd1;
  localparam logic [3:0] TYPE_IARITH = 4'd2;
  localparam logic [3:0] TYPE_LOAD   = 4'd3;
  localparam logic [3:0] TYPE_STORE  = 4'd4;
  localparam logic [3:0] TYPE_BRANCH = 4'd5;
  localparam logic [3:0] TYPE_JUMP   = 4'd6;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  // Address arithmetic wraps mod 2^32, so 32'hFFFF_FFFC + 4 gives 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_ins_classify.sv
// Combinational opcode -> instruction class decoder; also reused by trace/debug logic.
module ins_classify
  import if_stage_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [3:0] type_o
);

  // Map the primary opcode field onto the IF_ins_type class codes.
  always_comb begin
    type_o = TYPE_NOP;
    case (opcode_i)
      OP_RTYPE:                     type_o = TYPE_RTYPE;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI:    type_o = TYPE_IARITH;
      OP_LW:                        type_o = TYPE_LOAD;
      OP_SW:                        type_o = TYPE_STORE;
      OP_BEQ, OP_BNE:               type_o = TYPE_BRANCH;
      OP_J, OP_JAL:                 type_o = TYPE_JUMP;
      default:                      type_o = TYPE_NOP;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC/fetch FSM over a req/ack instruction memory and
// the registered IF/ID interface towards decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  next_pc_q, next_pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         req_q, req_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [3:0]   type_q, type_d;
  logic [3:0]   num_q, num_d;
  logic         ack_s;
  logic         load_s;
  logic         bubble_s;
  logic [31:0]  word_s;
  logic [3:0]   word_type_s;

  // An ack only counts while a request is actually outstanding.
  assign ack_s = imem_ack & req_q;

  ins_classify u_classify (
    .opcode_i (word_s[31:26]),
    .type_o   (word_type_s)
  );

  // Fetch FSM: next state, PC bookkeeping and IF/ID load/bubble decisions.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    next_pc_d    = next_pc_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    load_s       = 1'b0;
    bubble_s     = 1'b0;
    word_s       = imem_rdata;
    case (state_q)
      S_REQ: begin
        if (!req_q) begin
          // First cycle after reset: nothing in flight, so a branch just retargets.
          if (branch_taken) begin
            fetch_addr_d = branch_target;
          end else begin
            fetch_addr_d = fetch_addr_q;
          end
          bubble_s = branch_taken | ~stall;
        end else if (ack_s) begin
          if (branch_taken) begin
            fetch_addr_d = branch_target;
            bubble_s     = 1'b1;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            load_s       = 1'b1;
            cnt_d        = cnt_q + 4'd1;
            fetch_addr_d = pc_plus4(fetch_addr_q);
          end
        end else if (branch_taken) begin
          next_pc_d = branch_target;
          state_d   = S_DISCARD;
          bubble_s  = 1'b1;
        end else begin
          bubble_s = ~stall;
        end
      end
      S_HOLD: begin
        word_s = hold_q;
        if (branch_taken) begin
          fetch_addr_d = branch_target;
          state_d      = S_REQ;
          bubble_s     = 1'b1;
        end else if (!stall) begin
          load_s       = 1'b1;
          cnt_d        = cnt_q + 4'd1;
          fetch_addr_d = pc_plus4(fetch_addr_q);
          state_d      = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DISCARD: begin
        if (branch_taken) begin
          next_pc_d = branch_target;
        end else begin
          next_pc_d = next_pc_q;
        end
        if (ack_s) begin
          fetch_addr_d = branch_taken ? branch_target : next_pc_q;
          state_d      = S_REQ;
        end else begin
          state_d = S_DISCARD;
        end
        bubble_s = branch_taken | ~stall;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
    req_d = (state_d != S_HOLD);
  end

  // IF/ID register next values: real instruction, bubble, or hold.
  always_comb begin
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    type_d  = type_q;
    num_d   = num_q;
    if (load_s) begin
      inst_d  = word_s;
      pc4_d   = pc_plus4(fetch_addr_q);
      valid_d = 1'b1;
      type_d  = word_type_s;
      num_d   = cnt_q;
    end else if (bubble_s) begin
      inst_d  = 32'h0000_0000;
      valid_d = 1'b0;
      type_d  = TYPE_NOP;
      num_d   = cnt_q;
    end else begin
      inst_d = inst_q;
    end
  end

  // State, PC and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      fetch_addr_q <= RESET_PC;
      next_pc_q    <= RESET_PC;
      hold_q       <= 32'h0000_0000;
      req_q        <= 1'b0;
      cnt_q        <= 4'd0;
      inst_q       <= 32'h0000_0000;
      pc4_q        <= 32'h0000_0000;
      valid_q      <= 1'b0;
      type_q       <= TYPE_NOP;
      num_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      next_pc_q    <= next_pc_d;
      hold_q       <= hold_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      type_q       <= type_d;
      num_q        <= num_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = fetch_addr_q;
  assign if_inst       = inst_q;
  assign if_pc4        = pc4_q;
  assign if_valid      = valid_q;
  assign IF_ins_type   = type_q;
  assign IF_ins_number = num_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage: a table of per-cycle stimulus with expected
// IF/ID and memory-port values, then mid-handshake reset and a sequential-fetch run.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [3:0]  IF_ins_type;
  logic [3:0]  IF_ins_number;

  int n_cmp;
  int n_bad;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_inst       (if_inst),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid),
    .IF_ins_type   (IF_ins_type),
    .IF_ins_number (IF_ins_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [3:0]  e_type;
    logic [3:0]  e_num;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic a, input logic [31:0] d, input logic rq,
                              input logic [31:0] ad, input logic [31:0] in,
                              input logic [31:0] p4, input logic v,
                              input logic [3:0] ty, input logic [3:0] nm);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.ack = a; r.rdata = d;
    r.e_req = rq; r.e_addr = ad; r.e_inst = in; r.e_pc4 = p4;
    r.e_valid = v; r.e_type = ty; r.e_num = nm;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic rq, input logic [31:0] ad,
                         input logic [31:0] in, input logic [31:0] p4, input logic v,
                         input logic [3:0] ty, input logic [3:0] nm);
    chk("imem_req", idx, {31'd0, imem_req}, {31'd0, rq});
    chk("imem_addr", idx, imem_addr, ad);
    chk("if_inst", idx, if_inst, in);
    chk("if_pc4", idx, if_pc4, p4);
    chk("if_valid", idx, {31'd0, if_valid}, {31'd0, v});
    chk("IF_ins_type", idx, {28'd0, IF_ins_type}, {28'd0, ty});
    chk("IF_ins_number", idx, {28'd0, IF_ins_number}, {28'd0, nm});
  endtask

  initial begin
    int k;
    int cyc;
    logic exp_load;

    n_cmp = 0;
    n_bad = 0;
    // stall br target ack rdata | req addr inst pc4 valid type num
    vecs[0]  = mk(0,0,32'h0,  0,32'h0,        1,32'h0,  32'h0,        32'h0, 0,4'd0,4'd0);
    vecs[1]  = mk(0,0,32'h0,  1,32'h8C010004, 1,32'h4,  32'h8C010004, 32'h4, 1,4'd3,4'd0);
    vecs[2]  = mk(0,0,32'h0,  1,32'h00221820, 1,32'h8,  32'h00221820, 32'h8, 1,4'd1,4'd1);
    vecs[3]  = mk(1,0,32'h0,  1,32'hAC030008, 0,32'h8,  32'h00221820, 32'h8, 1,4'd1,4'd1);
    vecs[4]  = mk(1,0,32'h0,  0,32'h0,        0,32'h8,  32'h00221820, 32'h8, 1,4'd1,4'd1);
    vecs[5]  = mk(1,0,32'h0,  0,32'h0,        0,32'h8,  32'h00221820, 32'h8, 1,4'd1,4'd1);
    vecs[6]  = mk(0,0,32'h0,  0,32'h0,        1,32'hC,  32'hAC030008, 32'hC, 1,4'd4,4'd2);
    vecs[7]  = mk(0,1,32'h40, 0,32'h0,        1,32'hC,  32'h0,        32'hC, 0,4'd0,4'd3);
    vecs[8]  = mk(0,0,32'h0,  0,32'h0,        1,32'hC,  32'h0,        32'hC, 0,4'd0,4'd3);
    vecs[9]  = mk(0,0,32'h0,  1,32'h10220003, 1,32'h40, 32'h0,        32'hC, 0,4'd0,4'd3);
    vecs[10] = mk(0,0,32'h0,  1,32'h08000010, 1,32'h44, 32'h08000010, 32'h44,1,4'd6,4'd3);
    vecs[11] = mk(1,0,32'h0,  1,32'h20420001, 0,32'h44, 32'h08000010, 32'h44,1,4'd6,4'd3);
    vecs[12] = mk(1,1,32'h100,0,32'h0,        1,32'h100,32'h0,        32'h44,0,4'd0,4'd4);
    vecs[13] = mk(0,0,32'h0,  1,32'h0C000020, 1,32'h104,32'h0C000020, 32'h104,1,4'd6,4'd4);
    vecs[14] = mk(0,1,32'h200,1,32'h8C000000, 1,32'h200,32'h0,        32'h104,0,4'd0,4'd5);
    vecs[15] = mk(0,0,32'h0,  1,32'h34420005, 1,32'h204,32'h34420005, 32'h204,1,4'd2,4'd5);
    vecs[16] = mk(1,0,32'h0,  0,32'h0,        1,32'h204,32'h34420005, 32'h204,1,4'd2,4'd5);
    vecs[17] = mk(0,0,32'h0,  0,32'h0,        1,32'h204,32'h0,        32'h204,0,4'd0,4'd6);
    vecs[18] = mk(0,1,32'h300,0,32'h0,        1,32'h204,32'h0,        32'h204,0,4'd0,4'd6);
    vecs[19] = mk(0,1,32'h400,0,32'h0,        1,32'h204,32'h0,        32'h204,0,4'd0,4'd6);
    vecs[20] = mk(0,0,32'h0,  1,32'h14000000, 1,32'h400,32'h0,        32'h204,0,4'd0,4'd6);
    vecs[21] = mk(0,0,32'h0,  1,32'h14220002, 1,32'h404,32'h14220002, 32'h404,1,4'd5,4'd6);
    vecs[22] = mk(0,1,32'hFFFFFFFC,1,32'h0,   1,32'hFFFFFFFC,32'h0,   32'h404,0,4'd0,4'd7);
    vecs[23] = mk(0,0,32'h0,  1,32'h3C010001, 1,32'h0,  32'h3C010001, 32'h0, 1,4'd0,4'd7);

    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    @(negedge clk);
    chk_all(-1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      stall = vecs[i].stall;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      imem_ack = vecs[i].ack;
      imem_rdata = vecs[i].rdata;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_inst, vecs[i].e_pc4,
              vecs[i].e_valid, vecs[i].e_type, vecs[i].e_num);
    end

    // Reset while a request is outstanding: everything clears without a clock edge.
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(100, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch with periodic memory waits; the tag wraps 15 -> 0.
    k = 0;
    cyc = 0;
    while (k < 20 && cyc < 80) begin
      exp_load = imem_req && ((cyc % 4) != 2);
      imem_ack = exp_load;
      imem_rdata = 32'h8C000000 | imem_addr;
      @(posedge clk);
      #1;
      if (exp_load) begin
        chk("seq_inst", k, if_inst, 32'h8C000000 | (k * 4));
        chk("seq_pc4", k, if_pc4, (k + 1) * 4);
        chk("seq_valid", k, {31'd0, if_valid}, 32'd1);
        chk("seq_type", k, {28'd0, IF_ins_type}, 32'd3);
        chk("seq_num", k, {28'd0, IF_ins_number}, k % 16);
        k++;
      end else begin
        chk("bub_valid", cyc, {31'd0, if_valid}, 32'd0);
        chk("bub_num", cyc, {28'd0, IF_ins_number}, k % 16);
        chk("bub_pc4", cyc, if_pc4, k * 4);
      end
      cyc++;
    end
    chk("seq_deliveries", cyc, k, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
